// File: rtl/freqsep_band_accum_if.sv
// Stream bundle for the per-band energy accumulator.
// Carries the magnitude input beat (valid/ready, magnitude, sop/eop) and the
// band result handshake with the four accumulated band values.
//   master : upstream source / result consumer side
//   slave  : accumulator side
interface freqsep_band_accum_if #(
    parameter int MAG_W = 16,
    parameter int ACC_W = 24
);
    logic             in_valid;
    logic             in_ready;
    logic [MAG_W-1:0] in_mag;
    logic             in_sop;
    logic             in_eop;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_band0;
    logic [ACC_W-1:0] out_band1;
    logic [ACC_W-1:0] out_band2;
    logic [ACC_W-1:0] out_band3;

    modport master (
        output in_valid, in_mag, in_sop, in_eop, out_ready,
        input  in_ready, out_valid, out_band0, out_band1, out_band2, out_band3
    );

    modport slave (
        input  in_valid, in_mag, in_sop, in_eop, out_ready,
        output in_ready, out_valid, out_band0, out_band1, out_band2, out_band3
    );
endinterface

// File: rtl/freqsep_band_accum.sv
// Per-band energy accumulator for one spectral frame.
// Each accepted magnitude beat is one frequency bin; its bin index is compared
// against three boundaries (latched from freqsep at sop) to pick one of four
// bands, and the magnitude is added into that band with saturation. At eop the
// four sums are presented and held until the consumer accepts them.
// Ports:
//   clk      : clock, rising edge
//   reset_n  : asynchronous active-low reset
//   freqsep  : band boundaries b0=[7:0], b1=[15:8], b2=[23:16]
//   bus      : slave side of freqsep_band_accum_if (input stream + results)
module freqsep_band_accum #(
    parameter int MAG_W = 16,
    parameter int ACC_W = 24
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [23:0]          freqsep,
    freqsep_band_accum_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

    state_t           state, state_nxt;
    logic [23:0]      bnd;
    logic [7:0]       bin_idx;
    logic [ACC_W-1:0] acc [4];

    logic             accept;
    logic             start;
    logic             step;
    logic [7:0]       idx_cur;
    logic [23:0]      bnd_cur;
    logic [1:0]       sel;

    // First match wins, so non-monotonic boundaries simply leave bands empty.
    function automatic logic [1:0] band_of(input logic [7:0] idx, input logic [23:0] b);
        if (idx < b[7:0])        return 2'd0;
        else if (idx < b[15:8])  return 2'd1;
        else if (idx < b[23:16]) return 2'd2;
        else                     return 2'd3;
    endfunction

    function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] a,
                                                 input logic [MAG_W-1:0] m);
        logic [ACC_W:0] s;
        s = {1'b0, a} + (ACC_W+1)'(m);
        if (s[ACC_W]) return {ACC_W{1'b1}};
        else          return s[ACC_W-1:0];
    endfunction

    function automatic logic [7:0] idx_inc(input logic [7:0] i);
        return (i == 8'hFF) ? 8'hFF : i + 8'd1;
    endfunction

    // A sop beat in IDLE or ACCUM (re)starts a frame; other accepted beats
    // only count while a frame is open, so stray beats in IDLE are dropped.
    assign accept  = bus.in_valid && bus.in_ready;
    assign start   = accept && bus.in_sop;
    assign step    = accept && !bus.in_sop && (state == ACCUM);

    // The sop beat is bin 0 and must already use the boundaries being latched.
    assign idx_cur = bus.in_sop ? 8'd0 : idx_inc(bin_idx);
    assign bnd_cur = bus.in_sop ? freqsep : bnd;
    assign sel     = band_of(idx_cur, bnd_cur);

    always_comb begin
        state_nxt     = state;
        bus.in_ready  = 1'b1;
        bus.out_valid = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = bus.in_eop ? HOLD : ACCUM;
            end
            ACCUM: begin
                if (accept) state_nxt = bus.in_eop ? HOLD : ACCUM;
            end
            HOLD: begin
                bus.in_ready  = 1'b0;
                bus.out_valid = 1'b1;
                if (bus.out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bnd     <= '0;
            bin_idx <= '0;
            for (int k = 0; k < 4; k++) acc[k] <= '0;
        end else if (start) begin
            bnd     <= freqsep;
            bin_idx <= 8'd0;
            for (int k = 0; k < 4; k++)
                acc[k] <= (sel == 2'(k)) ? ACC_W'(bus.in_mag) : '0;
        end else if (step) begin
            bin_idx  <= idx_cur;
            acc[sel] <= sat_add(acc[sel], bus.in_mag);
        end
    end

    // Results come straight from the accumulators; valid only in HOLD.
    assign bus.out_band0 = acc[0];
    assign bus.out_band1 = acc[1];
    assign bus.out_band2 = acc[2];
    assign bus.out_band3 = acc[3];

endmodule
